pipelined_datapath: RTL
=======================

Name: pipelined_datapath

Overview:
- Parametrised successor of the single-cycle register-file/shifter/ALU datapath.
- Accepts one micro-op per cycle on a valid/ready stream and executes it in a 2-stage pipeline: operand fetch, then execute/writeback.
- Produces a result stream with registered Z/N/V status, with backpressure.
- Configurable data width and register count; correct signed overflow; same-cycle write-to-read bypass.
- Sits between the instruction-sequencer FSM and memory/output logic.

Parameters:
- DATA_W, 16, datapath and register width (>=4)
- NREGS, 8, number of general registers (power of two, >=2)
- AW, $clog2(NREGS), register-index width (derived, not overridden)
- PC_W, 8, program-counter width (<= DATA_W)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  micro-op present
- in_ready  out  1  micro-op accepted when in_valid&&in_ready
- in_rd_a  in  AW  A-operand register index
- in_rd_b  in  AW  B-operand register index
- in_wr  in  AW  destination register index
- in_we  in  1  write destination register
- in_vsel  in  2  writeback source: 00 ALU, 01 in_mdata, 10 in_imm, 11 zero-extended in_pc
- in_alu_op  in  2  00 add, 01 sub, 10 and, 11 not-B
- in_shift  in  2  B shift: 00 none, 01 lsl1, 10 lsr1, 11 asr1
- in_asel  in  1  1: A operand forced to 0
- in_bsel  in  1  1: B operand = in_imm (unshifted)
- in_load_flags  in  1  update status flags
- in_imm  in  DATA_W  sign-extended immediate
- in_mdata  in  DATA_W  memory read data
- in_pc  in  PC_W  program counter
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid&&out_ready
- out_data  out  DATA_W  selected writeback value
- out_z, out_n, out_v  out  1 each  registered status flags

Behaviour:
- Reset (async assert, sync-safe deassert): all registers = 0; out_data, out_z, out_n, out_v = 0; out_valid = 0; exec stage empty; in_ready = 1 after reset.
- Reset mid-operation discards all in-flight ops; no partial writeback.
- Stage F (accept cycle T):
  - Read both operands; shift B.
  - Capture the op, operands, imm, mdata and pc into exec registers; exec_valid = 1.
- Stage E (cycle T+1):
  - Compute A' = asel ? 0 : A; B' = bsel ? imm : shifted B.
  - Compute ALU on A'/B'; select writeback value by vsel.
  - Advance when out stage is empty or draining: !out_valid || out_ready.
  - On advance, and only on advance:
    - Register write if in_we.
    - out_data = selected value.
    - Flags from the ALU result (not the vsel value) if load_flags; otherwise flags hold.
    - out_valid = 1.
  - Each op writes the register file exactly once.
- Latency: accept at T gives out_valid at T+2 with no backpressure. Throughput is 1 op/cycle.
- in_ready = !exec_valid || exec_advance (combinational).
- Stall: exec registers and out registers hold while out_valid && !out_ready. in_valid may drop without penalty.
- Bypass: if E advances with in_we and in_wr matches in_rd_a/in_rd_b of the op accepted that same cycle, F captures the new write data, not the stale register. Both ports are bypassed independently.
- Flags:
  - Z = result==0.
  - N = result[DATA_W-1].
  - V = signed overflow: add → operands same sign, result sign differs; sub → operands differ in sign, result sign differs from A'; and/not → V = 0.
- Arithmetic is modulo 2^DATA_W. asr replicates the MSB; lsl/lsr shift in 0.
- Simultaneous out handshake and E advance in the same cycle loads the new result; no bubble.

Optional Feature:
- Macro CARRY_FLAG_EN.
- Defined:
  - Adds output port out_c (1 bit), reset 0, loaded with flags.
  - add → carry-out of bit DATA_W-1; sub → NOT borrow (A' >= B' unsigned); and/not → 0.
- Undefined:
  - No out_c port; the carry chain is not generated; all other behaviour identical.

Decomposition:
- Package datapath_pkg holds:
  - ALU op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT).
  - Shift encodings (SH_NONE, SH_LSL, SH_LSR, SH_ASR).
  - vsel encodings (VS_ALU, VS_MDATA, VS_IMM, VS_PC).
  - A packed micro-op struct typedef.
- One sub-module, dp_regfile: parametrised NREGS x DATA_W, async reset, one write port, two combinational read ports with write-bypass.
- ALU and shifter stay inline.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 2 ops in flight → out_valid=0, flags 0, reading R3 afterwards returns 0x0000.
- Back-to-back dependency: imm 0x0005→R1, then R2=R1+R1 accepted next cycle → second result 0x000A via bypass; out_valid on consecutive cycles.
- Signed overflow: R0=0x7FFF, R1=0x0001, add with load_flags → out_data=0x8000, N=1, V=1, Z=0. Sub 0x8000-0x0001 → 0x7FFF, V=1.
- Shift/select: B=0x8002, asr, bsel=0 → 0xC001. bsel=1, imm=0xFFF0 → shifter ignored. asel=1 with add → result = B'.
- Backpressure: out_ready=0 for 5 cycles with 3 ops offered → in_ready drops after 2 accepts, R writes deferred; release → 3 results in order, each register written once.
- CARRY_FLAG_EN: 0xFFFF+0x0001 → out_c=1, Z=1, V=0. 0x0003-0x0005 → out_c=0, N=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// ---------------------------------------------------------------------------
// datapath_pkg: shared encodings and micro-op control struct.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package datapath_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [1:0] VS_ALU   = 2'b00;
  localparam logic [1:0] VS_MDATA = 2'b01;
  localparam logic [1:0] VS_IMM   = 2'b10;
  localparam logic [1:0] VS_PC    = 2'b11;

  // Control fields still needed in the execute stage; the shift is applied at fetch.
  typedef struct packed {
    logic       we;
    logic [1:0] vsel;
    logic [1:0] alu_op;
    logic       asel;
    logic       bsel;
    logic       load_flags;
  } uop_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/dp_regfile.sv
// ---------------------------------------------------------------------------
// dp_regfile: NREGS x DATA_W register file, one write port, two bypassed reads.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dp_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // A write landing this cycle is forwarded so the reader sees the new value.
  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

`default_nettype wire

// File: rtl/pipelined_datapath.sv
// ---------------------------------------------------------------------------
// pipelined_datapath: 2-stage regfile/shifter/ALU pipeline with valid/ready
// streams. Optional macro CARRY_FLAG_EN adds the out_c carry flag.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int PC_W   = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rd_a,
  input  logic [AW-1:0]     in_rd_b,
  input  logic [AW-1:0]     in_wr,
  input  logic              in_we,
  input  logic [1:0]        in_vsel,
  input  logic [1:0]        in_alu_op,
  input  logic [1:0]        in_shift,
  input  logic              in_asel,
  input  logic              in_bsel,
  input  logic              in_load_flags,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_mdata,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_z,
  output logic              out_n,
`ifdef CARRY_FLAG_EN
  output logic              out_c,
`endif
  output logic              out_v
);

  localparam int MSB = DATA_W - 1;

  logic              exec_valid;
  uop_ctrl_t         exec_ctrl;
  logic [AW-1:0]     exec_wr;
  logic [DATA_W-1:0] exec_a, exec_b, exec_imm, exec_mdata;
  logic [PC_W-1:0]   exec_pc;

  logic              exec_advance, accept;
  logic [DATA_W-1:0] rdata_a, rdata_b, b_shifted;
  logic [DATA_W-1:0] a_op, b_op, alu_res, wb_val, pc_ext;
  logic              alu_v;
`ifdef CARRY_FLAG_EN
  logic              alu_c;
  logic [DATA_W:0]   alu_wide;
`endif

  assign exec_advance = exec_valid && (!out_valid || out_ready);
  assign in_ready     = !exec_valid || exec_advance;
  assign accept       = in_valid && in_ready;

  dp_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (exec_advance && exec_ctrl.we),
    .waddr   (exec_wr),
    .wdata   (wb_val),
    .raddr_a (in_rd_a),
    .raddr_b (in_rd_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_comb begin
    case (in_shift)
      SH_LSL:  b_shifted = {rdata_b[MSB-1:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, rdata_b[MSB:1]};
      SH_ASR:  b_shifted = {rdata_b[MSB], rdata_b[MSB:1]};
      default: b_shifted = rdata_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_valid <= 1'b0;
      exec_ctrl  <= '0;
      exec_wr    <= '0;
      exec_a     <= '0;
      exec_b     <= '0;
      exec_imm   <= '0;
      exec_mdata <= '0;
      exec_pc    <= '0;
    end else if (accept) begin
      exec_valid            <= 1'b1;
      exec_ctrl.we          <= in_we;
      exec_ctrl.vsel        <= in_vsel;
      exec_ctrl.alu_op      <= in_alu_op;
      exec_ctrl.asel        <= in_asel;
      exec_ctrl.bsel        <= in_bsel;
      exec_ctrl.load_flags  <= in_load_flags;
      exec_wr               <= in_wr;
      exec_a                <= rdata_a;
      exec_b                <= b_shifted;
      exec_imm              <= in_imm;
      exec_mdata            <= in_mdata;
      exec_pc               <= in_pc;
    end else if (exec_advance) begin
      exec_valid <= 1'b0;
    end
  end

  always_comb begin
    a_op    = exec_ctrl.asel ? '0 : exec_a;
    b_op    = exec_ctrl.bsel ? exec_imm : exec_b;
    alu_res = '0;
    alu_v   = 1'b0;
`ifdef CARRY_FLAG_EN
    alu_c    = 1'b0;
    alu_wide = '0;
`endif
    case (exec_ctrl.alu_op)
      ALU_ADD: begin
`ifdef CARRY_FLAG_EN
        alu_wide = {1'b0, a_op} + {1'b0, b_op};
        alu_res  = alu_wide[MSB:0];
        alu_c    = alu_wide[DATA_W];
`else
        alu_res = a_op + b_op;
`endif
        alu_v = (a_op[MSB] == b_op[MSB]) && (alu_res[MSB] != a_op[MSB]);
      end
      ALU_SUB: begin
`ifdef CARRY_FLAG_EN
        // Top bit of the widened difference is the borrow; carry is its inverse.
        alu_wide = {1'b0, a_op} - {1'b0, b_op};
        alu_res  = alu_wide[MSB:0];
        alu_c    = ~alu_wide[DATA_W];
`else
        alu_res = a_op - b_op;
`endif
        alu_v = (a_op[MSB] != b_op[MSB]) && (alu_res[MSB] != a_op[MSB]);
      end
      ALU_AND: alu_res = a_op & b_op;
      default: alu_res = ~b_op;
    endcase
  end

  always_comb begin
    pc_ext            = '0;
    pc_ext[PC_W-1:0]  = exec_pc;
    case (exec_ctrl.vsel)
      VS_MDATA: wb_val = exec_mdata;
      VS_IMM:   wb_val = exec_imm;
      VS_PC:    wb_val = pc_ext;
      default:  wb_val = alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_z     <= 1'b0;
      out_n     <= 1'b0;
      out_v     <= 1'b0;
`ifdef CARRY_FLAG_EN
      out_c     <= 1'b0;
`endif
    end else if (exec_advance) begin
      out_valid <= 1'b1;
      out_data  <= wb_val;
      if (exec_ctrl.load_flags) begin
        out_z <= (alu_res == '0);
        out_n <= alu_res[MSB];
        out_v <= alu_v;
`ifdef CARRY_FLAG_EN
        out_c <= alu_c;
`endif
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
